// File: rtl/aes_round_sequencer.sv
// Control FSM for the AES encryption round datapath: fetches each round key from
// the key schedule, then fires one load / round / final-round strobe per key.
module aes_round_sequencer #(
    parameter int Nk = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    input  logic       abort,
    input  logic       rk_ack,
    output logic       rk_req,
    output logic [3:0] round_idx,
    output logic       dp_load,
    output logic       dp_round,
    output logic       dp_final,
    output logic       busy,
    output logic       done,
    output logic       result_valid
);

    localparam int         Nr     = Nk + 6;
    localparam logic [3:0] NR_IDX = 4'(Nr);

    generate
        if (!(Nk == 4 || Nk == 6 || Nk == 8)) begin : g_illegal_nk
            $error("aes_round_sequencer: Nk must be 4, 6 or 8");
        end
    endgenerate

    typedef enum logic [1:0] {
        IDLE,
        KEY_WAIT,
        APPLY,
        DONE
    } state_t;

    state_t state;

    // Every output is a flop loaded alongside the state, so none has a path from an input.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= IDLE;
            round_idx    <= '0;
            rk_req       <= 1'b0;
            dp_load      <= 1'b0;
            dp_round     <= 1'b0;
            dp_final     <= 1'b0;
            busy         <= 1'b0;
            done         <= 1'b0;
            result_valid <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments throughout, so the pulse defaults below
            // are simply overridden by later assignments in the same cycle.
            rk_req   <= 1'b0;
            dp_load  <= 1'b0;
            dp_round <= 1'b0;
            dp_final <= 1'b0;
            done     <= 1'b0;

            case (state)
                IDLE: begin
                    if (start) begin
                        state        <= KEY_WAIT;
                        round_idx    <= '0;
                        result_valid <= 1'b0;
                        rk_req       <= 1'b1;
                        busy         <= 1'b1;
                    end
                end

                KEY_WAIT: begin
                    if (abort) begin
                        state     <= IDLE;
                        round_idx <= '0;
                        busy      <= 1'b0;
                    end else if (rk_ack) begin
                        state    <= APPLY;
                        dp_load  <= (round_idx == 4'd0);
                        dp_round <= (round_idx != 4'd0) && (round_idx != NR_IDX);
                        dp_final <= (round_idx == NR_IDX);
                    end else begin
                        rk_req <= 1'b1;
                    end
                end

                APPLY: begin
                    if (abort) begin
                        state     <= IDLE;
                        round_idx <= '0;
                        busy      <= 1'b0;
                    end else if (round_idx == NR_IDX) begin
                        state <= DONE;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                    end else begin
                        state     <= KEY_WAIT;
                        round_idx <= round_idx + 4'd1;
                        rk_req    <= 1'b1;
                    end
                end

                DONE: begin
                    // round_idx keeps Nr until the next accepted start.
                    state        <= IDLE;
                    result_valid <= 1'b1;
                end

                default: begin
                    state     <= IDLE;
                    round_idx <= '0;
                    busy      <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: doc/aes_round_sequencer.md
Name: aes_round_sequencer

Overview:
Control FSM that sequences the AES encryption round datapath behind the SPI subordinate interface. On a start pulse (the SPI "message received" event, already synchronised into clk), it steps through the initial AddRoundKey, rounds 1..Nr-1 and the final round. Before each step it handshakes with the key-schedule unit for the matching round key. When the ciphertext is ready it raises done / result_valid so the SPI side can load the TX register.

Parameters:
Nk, 4, key length in 32-bit words: 4 = AES-128, 6 = AES-192, 8 = AES-256. Any other value is illegal; elaboration must fail.
Nr, Nk+6 (localparam, not overridable), number of rounds: 10, 12 or 14.

Ports:
clk  input  1  system clock, rising edge
rst_n  input  1  asynchronous active-low reset
start  input  1  request to encrypt the latched message; sampled only in IDLE
abort  input  1  cancel the operation in progress
rk_ack  input  1  key schedule: round key for round_idx is valid on its bus
rk_req  output  1  key schedule: request round key for round_idx
round_idx  output  4  current round number, 0..Nr
dp_load  output  1  datapath: state <= msg XOR rk[0]
dp_round  output  1  datapath: full round (SubBytes, ShiftRows, MixColumns, AddRoundKey)
dp_final  output  1  datapath: final round (no MixColumns)
busy  output  1  operation in progress
done  output  1  one-cycle pulse: ciphertext valid in datapath state register
result_valid  output  1  level: ciphertext valid, held until next accepted start

Behaviour:
- Reset (async assert, sync release): state IDLE; round_idx=0; all other outputs 0.
- States: IDLE, KEY_WAIT, APPLY, DONE. All outputs are decoded from registered state and counter only. No output has a combinational path from an input.
- IDLE:
  - start=1 -> KEY_WAIT, round_idx<=0, result_valid<=0.
  - start=0 -> stay in IDLE.
- KEY_WAIT:
  - rk_req=1.
  - rk_ack=1 -> APPLY.
  - rk_ack=0 -> stay; no timeout; rk_req holds.
- APPLY, lasts exactly one cycle; rk_req=0:
  - round_idx==0: dp_load=1.
  - 1 <= round_idx <= Nr-1: dp_round=1.
  - round_idx==Nr: dp_final=1.
  - Exactly one dp_* is high in APPLY. None is high in any other state.
- APPLY exit:
  - round_idx==Nr -> DONE.
  - Otherwise round_idx<=round_idx+1 and -> KEY_WAIT.
- DONE, one cycle: done=1, result_valid<=1 (visible from the next cycle), then -> IDLE. round_idx holds Nr until the next start.
- busy=1 in KEY_WAIT and APPLY; 0 in IDLE and DONE.
- Latency with rk_ack tied high: start sampled at edge E0; done is high in the cycle following edge E(2Nr+2).
  - Nk=4: done after edge 22.
  - Nk=6: done after edge 26.
  - Nk=8: done after edge 30.
  - Each rk_ack stall cycle adds exactly one cycle.
- start outside IDLE, including in DONE: ignored, no queueing.
- abort:
  - abort=1 in KEY_WAIT or APPLY -> IDLE next edge, round_idx<=0, no done, result_valid stays 0.
  - If abort and rk_ack are high together, abort wins.
  - abort in IDLE or DONE: no effect.
- round_idx never exceeds Nr; no wrap-around.
- rst_n asserted mid-operation: immediate return to the reset values; no done pulse.

Test Plan:
- Reset, Nk=4: hold rst_n=0 with start=1 -> all outputs 0, state stays IDLE. Release rst_n, pulse start, rk_ack tied 1 -> dp_load at idx 0, dp_round at idx 1..9, dp_final at idx 10; done after edge 22; busy high for 22 cycles; result_valid=1 afterwards.
- Key stall, Nk=4: rk_ack low 3 cycles in round 5 only -> rk_req stays high with round_idx=5 for 4 cycles; done after edge 25; the dp_* sequence is unchanged.
- Start while busy: second start pulse at edge 7 -> ignored; exactly one done, after edge 22; result_valid only cleared by a start accepted in IDLE.
- Abort in round 4, with rk_ack=1 in the same cycle -> IDLE next edge, round_idx=0, busy=0, no dp_* pulse, no done, result_valid=0. A following start then completes normally.
- Nk=8 and Nk=6 with rk_ack tied 1:
  - Nk=8: dp_final at idx 14, done after edge 30.
  - Nk=6: dp_final at idx 12, done after edge 26.
- Async reset mid-op: rst_n low between clock edges during round 3 -> outputs 0 immediately without waiting for a clock edge; after release, no done is seen until a new start.
